// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with frame-latched data and inter-digit blanking
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] CNT_INIT = 8'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic                    sync1_q, sync2_q, prev_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fd_q, fd_d;
  logic                    tick, wrap, show;
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction
  // Next-state logic; shadow word only reloads on entry or at the frame wrap, so a frame never tears
  always_comb begin
    tick     = sync2_q & ~prev_q;
    wrap     = idx_q == LAST;
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dps_d    = dps_q;
    fd_d     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          idx_d    = '0;
          cnt_d    = CNT_INIT;
          shadow_d = data_in;
          dps_d    = dp_in;
        end
        BLANK: begin
          state_d = (cnt_q == 8'd0) ? SHOW : BLANK;
          cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
        end
        SHOW: if (tick) begin
          state_d = BLANK;
          cnt_d   = CNT_INIT;
          idx_d   = wrap ? '0 : idx_q + 1'b1;
          if (wrap) begin
            shadow_d = data_in;
            dps_d    = dp_in;
            fd_d     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Output values derived from the next state so the display registers change on the same edge as the state
  always_comb begin
    show  = state_d == SHOW;
    an_d  = show ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    seg_d = show ? decode(shadow_d[idx_d*4 +: 4]) : 7'h7F;
    dp_d  = show ? ~dps_d[idx_d] : 1'b1;
  end
  // State, scan_clk synchroniser/edge detector and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      dps_q    <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dps_q    <= dps_d;
      sync1_q  <= scan_clk;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;
endmodule
